// File: rtl/rlecca_pkg.sv
// Shared definitions for the RLECCA line-feeder chain: default image geometry, counter widths
// and the feeder FSM encoding.
package rlecca_pkg;

  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;
  localparam int unsigned CW_DEF    = 10;
  localparam int unsigned RW_DEF    = 9;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/row_delay_feeder_line_ram.sv
// One-row, 1-bit line memory for row_delay_feeder. Single port, synchronous
// read-before-write: an enabled cycle returns the old contents of addr and stores wdata there.
// No reset on the array or the read register so it maps onto block or distributed RAM.
module line_ram_1b #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          rdata
);

  logic mem [DEPTH];
  logic rdata_q;

  // Read old value, then overwrite with the new pixel at the same address.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q    <= mem[addr];
      mem[addr]  <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/row_delay_feeder.sv
// Streaming binary-pixel line feeder: emits (current pixel, pixel directly above) with column,
// row, end-of-line and end-of-frame qualifiers, one clock after the pixel is accepted.
// Optional build macro TOP_ROW_ZERO_EN: force pix_prev to 0 on row 0 so the previous frame's
// last row (or uninitialised memory) never leaks into the top border.
module row_delay_feeder
  import rlecca_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned RW    = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          datavalid,
  input  logic          sof,
  input  logic          pix_in,
  output logic          dv_out,
  output logic          pix_cur,
  output logic          pix_prev,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          eol,
  output logic          frame_done,
  output logic          busy
);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;

  logic          accept;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          last_col;
  logic          last_row;
  logic          ram_rdata;

  logic          dv_out_q;
  logic          pix_cur_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          eol_q;
  logic          frame_done_q;

  // sof restarts at (0,0) from any state, so it overrides the running counters.
  assign accept   = datavalid & (sof | (state_q == StActive));
  assign pos_col  = sof ? '0 : col_cnt_q;
  assign pos_row  = sof ? '0 : row_cnt_q;
  assign last_col = (pos_col == CW'(IMG_W - 1));
  assign last_row = (pos_row == RW'(IMG_H - 1));

  // Next-state and raster-position counters; counters point at the next expected pixel.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (accept) begin
      if (last_col && last_row) begin
        state_d   = StIdle;
        col_cnt_d = '0;
        row_cnt_d = '0;
      end else begin
        state_d = StActive;
        if (last_col) begin
          col_cnt_d = '0;
          row_cnt_d = pos_row + RW'(1);
        end else begin
          col_cnt_d = pos_col + CW'(1);
          row_cnt_d = pos_row;
        end
      end
    end
  end

  // FSM and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Output registers: one-cycle latency, position flags aligned with pix_cur.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_out_q     <= 1'b0;
      pix_cur_q    <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      dv_out_q <= accept;
      if (accept) begin
        pix_cur_q    <= pix_in;
        col_q        <= pos_col;
        row_q        <= pos_row;
        eol_q        <= last_col;
        frame_done_q <= last_col & last_row;
      end else begin
        eol_q        <= 1'b0;
        frame_done_q <= 1'b0;
      end
    end
  end

  line_ram_1b #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_line_ram (
    .clk   (clk),
    .en    (accept),
    .addr  (pos_col),
    .wdata (pix_in),
    .rdata (ram_rdata)
  );

  assign dv_out     = dv_out_q;
  assign pix_cur    = pix_cur_q;
  assign col        = col_q;
  assign row        = row_q;
  assign eol        = eol_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == StActive);

  // RAM read register is not reset; qualify with dv_out so idle/reset output reads 0.
`ifdef TOP_ROW_ZERO_EN
  assign pix_prev = dv_out_q & ram_rdata & (row_q != '0);
`else
  assign pix_prev = dv_out_q & ram_rdata;
`endif

endmodule

// File: tb/tb_row_delay_feeder.sv
// Scoreboard bench for row_delay_feeder with a 4x3 image. A behavioural model tracks the
// raster index and a per-column copy of the last stored row; expected outputs are queued at
// issue time and a negedge monitor pops and compares whenever dv_out is seen.
module tb_row_delay_feeder;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned CW = 2;
  localparam int unsigned RW = 2;

  typedef struct {
    bit pix_cur;
    bit pix_prev;
    bit prev_known;
    int col;
    int row;
    bit eol;
    bit frame_done;
    bit busy;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          datavalid;
  logic          sof;
  logic          pix_in;
  logic          dv_out;
  logic          pix_cur;
  logic          pix_prev;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          eol;
  logic          frame_done;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int dv_count = 0;
  int eol_count = 0;
  int fd_count = 0;

  exp_t exp_q[$];

  // Reference model state: frame position as a linear raster index.
  bit m_active = 0;
  int m_index  = 0;
  int m_line[W];   // -1 = unknown contents

  row_delay_feeder #(
    .IMG_W (W),
    .IMG_H (H),
    .CW    (CW),
    .RW    (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .datavalid  (datavalid),
    .sof        (sof),
    .pix_in     (pix_in),
    .dv_out     (dv_out),
    .pix_cur    (pix_cur),
    .pix_prev   (pix_prev),
    .col        (col),
    .row        (row),
    .eol        (eol),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every presented output.
  always @(negedge clk) begin
    if (rst) begin
      if (dv_out) begin
        dv_count++;
        if (eol) eol_count++;
        if (frame_done) fd_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_dv_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pix_cur", int'(pix_cur), int'(e.pix_cur));
          if (e.prev_known) check("pix_prev", int'(pix_prev), int'(e.pix_prev));
          check("col", int'(col), e.col);
          check("row", int'(row), e.row);
          check("eol", int'(eol), int'(e.eol));
          check("frame_done", int'(frame_done), int'(e.frame_done));
          check("busy", int'(busy), int'(e.busy));
        end
      end else begin
        check("flags_without_dv", int'(eol | frame_done), 0);
      end
    end
  end

  // Drive one cycle of inputs and advance the model for what the next edge will accept.
  task automatic drive(input bit dv, input bit s, input bit p);
    exp_t e;
    int c;
    int r;
    @(posedge clk);
    #1;
    datavalid = dv;
    sof       = s;
    pix_in    = p;
    if (dv && (s || m_active)) begin
      if (s) m_index = 0;
      c = m_index % W;
      r = m_index / W;
      e.pix_cur    = p;
      e.col        = c;
      e.row        = r;
      e.eol        = (c == W - 1);
      e.frame_done = (m_index == W * H - 1);
`ifdef TOP_ROW_ZERO_EN
      e.prev_known = (r == 0) || (m_line[c] >= 0);
      e.pix_prev   = (r == 0) ? 1'b0 : (m_line[c] == 1);
`else
      e.prev_known = (m_line[c] >= 0);
      e.pix_prev   = (m_line[c] == 1);
`endif
      m_line[c] = int'(p);
      m_index++;
      if (m_index == W * H) begin
        m_index  = 0;
        m_active = 0;
      end else begin
        m_active = 1;
      end
      e.busy = m_active;
      exp_q.push_back(e);
    end
  endtask

  // mode 0: column parity, 1: random, 2: all ones. gap_pct: chance of an idle cycle.
  task automatic send_frame(input int mode, input int gap_pct, input int stop_at);
    bit p;
    for (int idx = 0; idx < W * H && idx < stop_at; idx++) begin
      while ($urandom_range(99) < gap_pct) drive(0, 0, 1'($urandom));
      case (mode)
        0:       p = 1'((idx % W) & 1);
        1:       p = 1'($urandom);
        default: p = 1'b1;
      endcase
      drive(1, idx == 0, p);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  int base_dv;
  int base_eol;
  int base_fd;

  initial begin
    for (int i = 0; i < W; i++) m_line[i] = -1;
    rst       = 1'b0;
    datavalid = 1'b0;
    sof       = 1'b0;
    pix_in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Test 1: reset mid-stream, then datavalid without sof is ignored.
    send_frame(1, 0, 5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    m_active = 0;
    m_index  = 0;
    check("rst_dv_out", int'(dv_out), 0);
    check("rst_outputs", int'({pix_cur, pix_prev, col, row, eol, frame_done, busy}), 0);
    datavalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    base_dv = dv_count;
    for (int i = 0; i < 4; i++) drive(1, 0, 1);
    idle(2);
    check("no_sof_ignored_dv", dv_count - base_dv, 0);
    check("no_sof_busy", int'(busy), 0);

    // Test 2 + 6: column-parity frame; eol per row, single frame_done, busy low afterwards.
    base_dv = dv_count; base_eol = eol_count; base_fd = fd_count;
    send_frame(0, 0, W * H);
    idle(2);
    check("parity_dv_count", dv_count - base_dv, W * H);
    check("parity_eol_count", eol_count - base_eol, H);
    check("parity_fd_count", fd_count - base_fd, 1);
    check("busy_after_done", int'(busy), 0);

    // Test 3: random gaps, random data.
    for (int f = 0; f < 4; f++) begin
      base_dv = dv_count; base_fd = fd_count;
      send_frame(1, 30, W * H);
      idle(2);
      check("gap_dv_count", dv_count - base_dv, W * H);
      check("gap_fd_count", fd_count - base_fd, 1);
    end

    // Test 4: sof at pixel (2,1) aborts the frame; only the restarted frame completes.
    base_fd = fd_count;
    send_frame(1, 0, W + 2);
    send_frame(1, 20, W * H);
    idle(2);
    check("abort_fd_count", fd_count - base_fd, 1);

    // Test 5: all-ones frame followed by another frame; row-0 pix_prev depends on the macro.
    send_frame(2, 0, W * H);
    send_frame(1, 10, W * H);
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
